// File: rtl/adc_channel_scheduler_pkg.sv
// adc_channel_scheduler_pkg
// Shared definitions for the ADC channel scheduler: channel count, default
// timing limits and the sequencer state encoding.
package adc_channel_scheduler_pkg;

  localparam int NUM_CH             = 4;
  localparam int CH_W               = 2;
  localparam int DEF_TIMEOUT_CYCLES = 200;
  localparam int DEF_EOC_LOW_WAIT   = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_START,
    S_WAIT_LO,
    S_WAIT_HI,
    S_READ,
    S_LATCH
  } state_e;

endpackage

// File: rtl/adc_rr_pick.sv
// adc_rr_pick
// Combinational round-robin picker: grants the first requesting channel after
// 'last', wrapping 3->0. 'last' itself is the lowest-priority candidate.
// Ports:
//   req     in  per-channel request
//   last    in  index of the most recently served channel
//   grant   out chosen channel (0 when nothing is requested)
//   any_req out at least one request is present
module adc_rr_pick
  import adc_channel_scheduler_pkg::*;
(
  input  logic [NUM_CH-1:0] req,
  input  logic [CH_W-1:0]   last,
  output logic [CH_W-1:0]   grant,
  output logic              any_req
);

  logic            found;
  logic [CH_W-1:0] idx;

  always_comb begin
    grant   = '0;
    found   = 1'b0;
    idx     = '0;
    any_req = |req;
    // i = NUM_CH wraps back onto 'last', so it is scanned last.
    for (int i = 1; i <= NUM_CH; i++) begin
      idx = last + CH_W'(i);
      if (!found && req[idx]) begin
        grant = idx;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/adc_channel_scheduler.sv
// adc_channel_scheduler
// Scans up to four ADC channels round-robin, drives the converter control
// strobes, supervises EOC with timeouts and keeps one result register per
// channel with unread / overwrite / timeout flags.
// Ports:
//   count_clock, rst          clock, async active-low reset
//   chan_en[3:0]              channels to scan
//   eoc, adc_data[7:0]        converter status and data bus
//   rd_sel[1:0], rd_ack       readout select / acknowledge
//   err_clr                   clear sticky timeout flags
//   start, ale, oe            registered converter strobes
//   address[2:0]              registered converter mux address
//   rd_data[7:0]              result of channel rd_sel
//   data_valid, overrun, err  per-channel status flags
//   busy                      sequencer not idle
module adc_channel_scheduler
  import adc_channel_scheduler_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int EOC_LOW_WAIT   = DEF_EOC_LOW_WAIT
) (
  input  logic              count_clock,
  input  logic              rst,
  input  logic [NUM_CH-1:0] chan_en,
  input  logic              eoc,
  input  logic [7:0]        adc_data,
  input  logic [CH_W-1:0]   rd_sel,
  input  logic              rd_ack,
  input  logic              err_clr,
  output logic              start,
  output logic              ale,
  output logic              oe,
  output logic [2:0]        address,
  output logic [7:0]        rd_data,
  output logic [NUM_CH-1:0] data_valid,
  output logic [NUM_CH-1:0] overrun,
  output logic [NUM_CH-1:0] err,
  output logic              busy
);

  localparam int              CNT_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] TO_LIM  = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] LOW_LIM = CNT_W'(EOC_LOW_WAIT);

  state_e                       state_q, state_d;
  logic [CH_W-1:0]              ch_q, ch_d;      // channel in service / last served
  logic [CNT_W-1:0]             cnt_q, cnt_d, cnt_inc;
  logic [CH_W-1:0]              addr_q, addr_d;
  logic                         start_q, start_d, ale_q, ale_d, oe_q, oe_d;
  logic [NUM_CH-1:0][7:0]       result_q, result_d;
  logic [NUM_CH-1:0]            dv_q, dv_d, ov_q, ov_d, err_q, err_d;

  logic [CH_W-1:0] grant;
  logic            any_req, arb, timeout, latch, ack_hit;

  adc_rr_pick u_pick (
    .req     (chan_en),
    .last    (ch_q),
    .grant   (grant),
    .any_req (any_req)
  );

  // Saturating increment: the counter never wraps past TIMEOUT_CYCLES.
  assign cnt_inc = (cnt_q == TO_LIM) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    cnt_d   = cnt_q;
    arb     = 1'b0;
    timeout = 1'b0;
    case (state_q)
      S_IDLE:   arb = 1'b1;
      S_SELECT: state_d = S_START;
      S_START: begin
        state_d = S_WAIT_LO;
        cnt_d   = '0;
      end
      S_WAIT_LO: begin
        cnt_d = cnt_inc;
        // A fast converter may never show eoc low; give up waiting for it.
        if (!eoc || cnt_inc == LOW_LIM) begin
          state_d = S_WAIT_HI;
          cnt_d   = '0;
        end
      end
      S_WAIT_HI: begin
        cnt_d = cnt_inc;
        if (eoc) begin
          state_d = S_READ;
        end else if (cnt_inc == TO_LIM) begin
          timeout = 1'b1;
          arb     = 1'b1;
        end
      end
      S_READ:   state_d = S_LATCH;
      S_LATCH:  arb = 1'b1;
      default:  state_d = S_IDLE;
    endcase
    // Arbitration: chain straight into the next conversion when possible.
    if (arb) begin
      if (any_req) begin
        state_d = S_SELECT;
        ch_d    = grant;
      end else begin
        state_d = S_IDLE;
      end
    end
  end

  // Strobes are registered and decoded from the next state so they line up
  // with the state they belong to.
  always_comb begin
    start_d = (state_d == S_START);
    ale_d   = (state_d == S_SELECT) || (state_d == S_START);
    oe_d    = (state_d == S_READ) || (state_d == S_LATCH);
    addr_d  = (state_d == S_SELECT) ? ch_d : addr_q;
  end

  assign latch   = (state_q == S_LATCH);
  assign ack_hit = rd_ack && (rd_sel == ch_q);

  always_comb begin
    result_d = result_q;
    dv_d     = dv_q;
    ov_d     = ov_q;
    err_d    = err_q;
    if (rd_ack) begin
      dv_d[rd_sel] = 1'b0;
      ov_d[rd_sel] = 1'b0;
    end
    // The write is applied after the ack so it wins a same-cycle collision;
    // an acknowledged old value is not counted as an overwrite.
    if (latch) begin
      result_d[ch_q] = adc_data;
      dv_d[ch_q]     = 1'b1;
      if (dv_q[ch_q] && !ack_hit) ov_d[ch_q] = 1'b1;
    end
    if (err_clr) err_d = '0;
    if (timeout) err_d[ch_q] = 1'b1;
  end

  always_ff @(posedge count_clock or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      ch_q     <= CH_W'(NUM_CH - 1);
      cnt_q    <= '0;
      addr_q   <= '0;
      start_q  <= 1'b0;
      ale_q    <= 1'b0;
      oe_q     <= 1'b0;
      result_q <= '0;
      dv_q     <= '0;
      ov_q     <= '0;
      err_q    <= '0;
    end else begin
      state_q  <= state_d;
      ch_q     <= ch_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      start_q  <= start_d;
      ale_q    <= ale_d;
      oe_q     <= oe_d;
      result_q <= result_d;
      dv_q     <= dv_d;
      ov_q     <= ov_d;
      err_q    <= err_d;
    end
  end

  assign start      = start_q;
  assign ale        = ale_q;
  assign oe         = oe_q;
  assign address    = {1'b0, addr_q};
  assign rd_data    = result_q[rd_sel];
  assign data_valid = dv_q;
  assign overrun    = ov_q;
  assign err        = err_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_adc_channel_scheduler.sv
module tb_adc_channel_scheduler;

  localparam int EOC_N = 10;   // converter busy time after eoc falls

  logic       count_clock = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] chan_en = '0;
  logic       eoc = 1'b1;
  logic [7:0] adc_data = '0;
  logic [1:0] rd_sel = '0;
  logic       rd_ack = 1'b0;
  logic       err_clr = 1'b0;
  logic       start, ale, oe, busy;
  logic [2:0] address;
  logic [7:0] rd_data;
  logic [3:0] data_valid, overrun, err;

  adc_channel_scheduler dut (
    .count_clock (count_clock),
    .rst         (rst),
    .chan_en     (chan_en),
    .eoc         (eoc),
    .adc_data    (adc_data),
    .rd_sel      (rd_sel),
    .rd_ack      (rd_ack),
    .err_clr     (err_clr),
    .start       (start),
    .ale         (ale),
    .oe          (oe),
    .address     (address),
    .rd_data     (rd_data),
    .data_valid  (data_valid),
    .overrun     (overrun),
    .err         (err),
    .busy        (busy)
  );

  always #5 count_clock = ~count_clock;

  int nchecks = 0;
  int nerrs   = 0;
  int cyc     = 0;
  int hold_ch = -1;   // channel whose eoc never rises again
  int conv_k  = -1;
  int sel_addr[$];
  int sel_cyc[$];

  // Converter model: eoc low from two cycles after the start cycle, high
  // again EOC_N cycles later; data is 0x40 + channel.
  initial begin
    forever begin
      @(posedge count_clock);
      #1;
      if (!rst)              conv_k = -1;
      else if (start)        conv_k = 0;
      else if (conv_k >= 0)  conv_k++;
      if (conv_k >= 2 && hold_ch == int'(address[1:0])) eoc = 1'b0;
      else eoc = !(conv_k >= 2 && conv_k < 2 + EOC_N);
      adc_data = 8'h40 + {6'd0, address[1:0]};
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Advance one cycle; log every SELECT cycle (ale without start).
  task automatic tick();
    @(posedge count_clock);
    #1;
    cyc++;
    if (ale && !start) begin
      sel_addr.push_back(int'(address[1:0]));
      sel_cyc.push_back(cyc);
    end
  endtask

  task automatic wait_sel(input int n, input int budget, input string nm);
    int k = 0;
    while (sel_addr.size() < n && k < budget) begin tick(); k++; end
    check(nm, 32'(sel_addr.size() >= n), 32'd1);
  endtask

  task automatic wait_idle(input int budget, input string nm);
    int k = 0;
    while (busy && k < budget) begin tick(); k++; end
    check(nm, 32'(busy), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge count_clock);
    rst = 1'b0; chan_en = '0; rd_ack = 1'b0; err_clr = 1'b0; hold_ch = -1;
    repeat (2) @(negedge count_clock);
    rst = 1'b1;
    sel_addr.delete();
    sel_cyc.delete();
  endtask

  function automatic int qa(input int i);
    return (i < sel_addr.size()) ? sel_addr[i] : -1;
  endfunction

  function automatic int qgap(input int i);
    return (i + 1 < sel_cyc.size()) ? sel_cyc[i+1] - sel_cyc[i] : -1;
  endfunction

  typedef struct {
    logic [3:0]      en;
    logic [4:0][1:0] seq;   // first five SELECT addresses, [0] first
    logic [3:0]      dv;
    logic [3:0]      ov;
  } vec_t;

  vec_t vecs[4];

  initial begin
    logic [4:0][1:0] got;
    vecs[0] = '{en: 4'b1111, seq: 10'b00_11_10_01_00, dv: 4'b1111, ov: 4'b0001};
    vecs[1] = '{en: 4'b0101, seq: 10'b00_10_00_10_00, dv: 4'b0101, ov: 4'b0101};
    vecs[2] = '{en: 4'b1000, seq: 10'b11_11_11_11_11, dv: 4'b1000, ov: 4'b1000};
    vecs[3] = '{en: 4'b0110, seq: 10'b01_10_01_10_01, dv: 4'b0110, ov: 4'b0110};

    // Reset state
    #12;
    check("rst_strobes", 32'({start, ale, oe}), 32'd0);
    check("rst_address", 32'(address), 32'd0);
    check("rst_flags", 32'({data_valid, overrun, err}), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    for (int k = 0; k < 4; k++) begin
      rd_sel = 2'(k); #1;
      check($sformatf("rst_result%0d", k), 32'(rd_data), 32'd0);
    end

    // Table-driven scans: five conversions, then disable and drain.
    for (int v = 0; v < 4; v++) begin
      do_reset();
      chan_en = vecs[v].en;
      wait_sel(5, 200, $sformatf("v%0d_sel_wait", v));
      chan_en = '0;
      wait_idle(60, $sformatf("v%0d_idle_wait", v));
      for (int i = 0; i < 5; i++) got[i] = 2'(qa(i));
      check($sformatf("v%0d_addr_seq", v), 32'(got), 32'(vecs[v].seq));
      for (int i = 0; i < 4; i++)
        check($sformatf("v%0d_period%0d", v, i), 32'(qgap(i)), 32'd16);
      check($sformatf("v%0d_data_valid", v), 32'(data_valid), 32'(vecs[v].dv));
      check($sformatf("v%0d_overrun", v), 32'(overrun), 32'(vecs[v].ov));
      check($sformatf("v%0d_err", v), 32'(err), 32'd0);
      for (int k = 0; k < 4; k++) begin
        rd_sel = 2'(k); #1;
        check($sformatf("v%0d_result%0d", v, k), 32'(rd_data),
              vecs[v].en[k] ? 32'h40 + 32'(k) : 32'd0);
      end
    end

    // Two full scans with no reads, then acknowledge channel 2.
    do_reset();
    chan_en = 4'b1111;
    wait_sel(9, 300, "ovr_sel_wait");
    chan_en = '0;
    wait_idle(60, "ovr_idle_wait");
    check("ovr_all", 32'(overrun), 32'hf);
    rd_sel = 2'd2; rd_ack = 1'b1;
    tick();
    rd_ack = 1'b0;
    check("ack_dv", 32'(data_valid), 32'b1011);
    check("ack_ov", 32'(overrun), 32'b1011);

    // Ack of channel 0 in the same cycle as its LATCH write.
    chan_en = 4'b0001;
    tick();
    chan_en = '0;
    begin
      int k = 0;
      while (!oe && k < 40) begin tick(); k++; end
      check("coll_read_wait", 32'(oe), 32'd1);
    end
    tick();                    // now in LATCH
    rd_sel = 2'd0; rd_ack = 1'b1;
    tick();
    rd_ack = 1'b0;
    check("coll_dv", 32'(data_valid), 32'b1011);
    check("coll_ov", 32'(overrun), 32'b1010);
    check("coll_data", 32'(rd_data), 32'h40);
    wait_idle(10, "coll_idle_wait");

    // Channel 1 times out; scan moves on to channel 2.
    do_reset();
    hold_ch = 1;
    chan_en = 4'b1111;
    wait_sel(3, 600, "to_sel_wait");
    check("to_addr1", 32'(qa(1)), 32'd1);
    check("to_addr2", 32'(qa(2)), 32'd2);
    check("to_gap_ok", 32'(qgap(0)), 32'd16);
    check("to_gap_timeout", 32'(qgap(1)), 32'd204);
    check("to_err", 32'(err), 32'b0010);
    check("to_dv1", 32'(data_valid[1]), 32'd0);
    rd_sel = 2'd1; #1;
    check("to_result1", 32'(rd_data), 32'd0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("errclr", 32'(err), 32'd0);
    // Hold err_clr across the next channel-1 timeout: the set must win.
    err_clr = 1'b1;
    wait_sel(7, 700, "to2_sel_wait");
    err_clr = 1'b0;
    check("to2_addr", 32'(qa(6)), 32'd2);
    check("to2_err_same_cycle", 32'(err), 32'b0010);
    chan_en = '0;
    wait_idle(60, "to2_idle_wait");
    hold_ch = -1;

    // Asynchronous reset during channel 3 readout.
    do_reset();
    chan_en = 4'b1111;
    wait_sel(4, 200, "ar_sel_wait");
    begin
      int k = 0;
      while (!oe && k < 40) begin tick(); k++; end
      check("ar_read_wait", 32'(oe), 32'd1);
    end
    #1 rst = 1'b0;
    #1;
    check("ar_strobes", 32'({start, ale, oe}), 32'd0);
    check("ar_busy", 32'(busy), 32'd0);
    check("ar_address", 32'(address), 32'd0);
    check("ar_dv", 32'(data_valid), 32'd0);
    rd_sel = 2'd3; #1;
    check("ar_result3", 32'(rd_data), 32'd0);
    @(negedge count_clock);
    sel_addr.delete();
    sel_cyc.delete();
    rst = 1'b1;
    wait_sel(1, 20, "ar_rel_sel_wait");
    check("ar_first_addr", 32'(qa(0)), 32'd0);

    // chan_en dropped mid-conversion of channel 0.
    do_reset();
    chan_en = 4'b1111;
    wait_sel(1, 10, "dis_sel_wait");
    chan_en = '0;
    wait_idle(40, "dis_idle_wait");
    check("dis_dv", 32'(data_valid), 32'b0001);
    check("dis_nsel", 32'(sel_addr.size()), 32'd1);

    $display("CHECKS %0d ERRORS %0d", nchecks, nerrs);
    $finish;
  end

endmodule

// File: doc/adc_channel_scheduler.md
ADC_CHANNEL_SCHEDULER -- requirements
Module: adc_channel_scheduler

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 200: maximum count_clock cycles allowed in each EOC wait state.
REQ-002 Parameter EOC_LOW_WAIT, default 8: maximum cycles allowed for eoc to fall after start.
REQ-003 count_clock  input  1  block clock; all state changes on the rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 chan_en  input  4  per-channel scan enable, channels 0..3.
REQ-006 eoc  input  1  converter end-of-conversion, high = done.
REQ-007 adc_data  input  8  converter output bus, valid while oe=1.
REQ-008 rd_sel  input  2  channel selected for readout.
REQ-009 rd_ack  input  1  consumer acknowledge for channel rd_sel.
REQ-010 err_clr  input  1  clears all sticky error flags.
REQ-011 start, ale, oe  output  1 each  registered converter control strobes.
REQ-012 address  output  3  registered converter mux address, bit 2 always 0.
REQ-013 rd_data  output  8  result register of channel rd_sel (combinational mux).
REQ-014 data_valid  output  4  per-channel unread-result flags.
REQ-015 overrun  output  4  per-channel sticky overwrite flags.
REQ-016 err  output  4  per-channel sticky timeout flags.
REQ-017 busy  output  1  high in every state except IDLE.

Function
REQ-018 States SHALL be IDLE, SELECT, START, WAIT_LO, WAIT_HI, READ, LATCH.
REQ-019 IDLE: when chan_en != 0, pick the channel, go SELECT; otherwise stay.
REQ-020 Channel pick SHALL be round-robin: first enabled channel after the last served one, wrapping 3->0; after reset the last served channel is 3.
REQ-021 SELECT: address = {0, ch}, ale=1; next state START.
REQ-022 START: ale=1, start=1 for exactly one cycle; clear timeout counter; next state WAIT_LO.
REQ-023 WAIT_LO: on eoc=0 go WAIT_HI and clear counter; if eoc stays high for EOC_LOW_WAIT cycles, go WAIT_HI anyway (fast converter).
REQ-024 WAIT_HI: on eoc=1 go READ; when counter reaches TIMEOUT_CYCLES, set err[ch], skip the data write, go to the arbitration step.
REQ-025 READ: oe=1; next state LATCH.
REQ-026 LATCH: oe=1; capture adc_data into result[ch]; set data_valid[ch]; go to the arbitration step.
REQ-027 Arbitration step: if chan_en != 0, go SELECT with the next round-robin channel (no IDLE cycle); else go IDLE.
REQ-028 Nominal conversion with eoc falling 1 cycle after start and rising N cycles later SHALL occupy exactly 6+N cycles from SELECT to LATCH, inclusive.
REQ-029 address SHALL be held constant from SELECT through LATCH or timeout exit.
REQ-030 A chan_en change mid-conversion SHALL NOT abort the current channel; it takes effect at the next arbitration step.
REQ-031 rd_ack with rd_sel=k SHALL clear data_valid[k] and overrun[k] on the next edge.
REQ-032 A LATCH write to channel k while data_valid[k]=1 SHALL set overrun[k].
REQ-033 A LATCH write and rd_ack on the same channel in the same cycle: the write wins; data_valid stays 1; overrun is not set.
REQ-034 err_clr SHALL clear all err bits; a same-cycle timeout on channel k SHALL leave err[k] set.
REQ-035 Timeout counter width SHALL be the minimum that holds TIMEOUT_CYCLES; it SHALL saturate and never wrap.

Reset
REQ-036 While rst=0: state IDLE; start, ale, oe = 0; address = 0; all result registers = 0; data_valid, overrun, err = 0; last served channel = 3; counter = 0.
REQ-037 Assertion of rst mid-conversion SHALL drop all strobes immediately (asynchronously); any partial result SHALL be discarded.

Structure
REQ-038 A shared package SHALL hold the state enumeration, channel count (4), and default TIMEOUT_CYCLES and EOC_LOW_WAIT.
REQ-039 The round-robin picker SHALL be a sub-module, adc_rr_pick: 4-bit request plus 2-bit last index in; 2-bit grant plus any-request flag out; combinational.

Verification
REQ-040 chan_en=4'b1111, model eoc falls 1 cycle after start and rises 10 cycles later, data=8'h40+ch -> address sequence 0,1,2,3,0; result[k]=8'h40+k; each conversion 16 cycles.
REQ-041 chan_en=4'b0101 -> only addresses 0 and 2 alternate; data_valid = 4'b0101.
REQ-042 Channel 1 eoc held low -> err[1]=1 after TIMEOUT_CYCLES=200 cycles in WAIT_HI; result[1] unchanged; scan continues with channel 2.
REQ-043 No rd_ack across two scans -> overrun = 4'b1111; rd_sel=2 with rd_ack -> data_valid[2]=0 and overrun[2]=0 on the next edge.
REQ-044 rst pulled low during WAIT_HI of channel 3 -> strobes 0 without waiting for a clock edge; after release the first conversion uses address 0.
REQ-045 chan_en set to 0 during channel 0 conversion -> channel 0 completes with LATCH, then IDLE with busy=0.
